// File: rtl/rca16_pkg.sv
// Shared types and constants for the 16-bit ripple-carry adder family.
package rca16_pkg;

  localparam int RCA_WIDTH = 16;

  typedef logic [RCA_WIDTH-1:0] rca_word_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ACCUM,
    ACC_DONE
  } acc_state_t;

endpackage : rca16_pkg

// File: rtl/ripplecarryadder16bit.sv
// 16-bit ripple-carry adder: sum = a + b + cin, carry-out on cout.
// Purely combinational; the carry ripples bit by bit from LSB to MSB.
module ripplecarryadder16bit
  import rca16_pkg::*;
(
  input  logic [RCA_WIDTH-1:0] a,
  input  logic [RCA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [RCA_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [RCA_WIDTH:0] carry;

  // Full-adder chain; carry[i] feeds bit i, carry[i+1] is its carry-out.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, first thing,
    // so no latch can be inferred.
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < RCA_WIDTH; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[RCA_WIDTH];
  end

endmodule : ripplecarryadder16bit

// File: rtl/rca16_accumulator.sv
// Multi-operand accumulator on top of ripplecarryadder16bit.
// Takes a packet of operands over a valid/ready stream (one per cycle),
// sums them and presents sum, sticky carry, operand count and a truncation
// flag on a valid/ready result port.
// Build option: define RCA16_ACC_SATURATE_EN to clamp the accumulator to
// all-ones on any carry-out instead of wrapping.
module rca16_accumulator
  import rca16_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int MAX_OPS = 255,
  localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  localparam logic [CNT_W-1:0] MAX_OPS_C = CNT_W'(MAX_OPS);
  localparam logic             SINGLE_OP = (MAX_OPS == 1);

  acc_state_t       state;
  acc_state_t       state_next;
  logic             run;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             carry;
  logic             trunc;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             beat;
  logic             at_limit;

  // run is 0 only while in reset and until the first clock edge after release,
  // which keeps in_ready low during that window.
  assign in_ready  = run & (state != ACC_DONE);
  assign out_valid = (state == ACC_DONE);
  assign beat      = in_valid & in_ready;
  assign count_inc = count + CNT_W'(1);
  assign at_limit  = (count_inc == MAX_OPS_C);

  assign out_sum   = acc;
  assign out_carry = carry;
  assign out_count = count;
  assign out_trunc = trunc;

  ripplecarryadder16bit u_adder (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef RCA16_ACC_SATURATE_EN
  // Clamp on overflow; all-ones plus anything nonzero carries again, so the
  // accumulator stays pinned for the rest of the packet.
  assign acc_next = add_cout ? '1 : add_sum;
`else
  // Plain modulo-2^WIDTH wrap.
  assign acc_next = add_sum;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= ACC_IDLE;
    else        state <= state_next;
  end

  // Next-state decode: packet end on in_last or when the operand limit is hit.
  always_comb begin
    state_next = state;
    case (state)
      ACC_IDLE:  if (beat) state_next = (in_last || SINGLE_OP) ? ACC_DONE : ACC_ACCUM;
      ACC_ACCUM: if (beat && (in_last || at_limit)) state_next = ACC_DONE;
      ACC_DONE:  if (out_ready) state_next = ACC_IDLE;
      default:   state_next = ACC_IDLE;
    endcase
  end

  // Datapath: load on first beat, accumulate on later beats, clear on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      acc   <= '0;
      count <= '0;
      carry <= 1'b0;
      trunc <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        ACC_IDLE: begin
          if (beat) begin
            acc   <= in_data;
            count <= CNT_W'(1);
            carry <= 1'b0;
            trunc <= 1'b0;
          end
        end
        ACC_ACCUM: begin
          if (beat) begin
            acc   <= acc_next;
            count <= count_inc;
            carry <= carry | add_cout;
            trunc <= ~in_last & at_limit;
          end
        end
        ACC_DONE: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            carry <= 1'b0;
            trunc <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : rca16_accumulator
